// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one combinational ALU between two requesters; accept-to-response is 2 cycles.
// A held response blocks new accepts until its owner takes it; the next grant overlaps that handshake.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req0_valid_i,
  input  logic             req1_valid_i,
  output logic             req0_ready_o,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req0_op_a_i,
  input  logic [WIDTH-1:0] req1_op_a_i,
  input  logic [WIDTH-1:0] req0_op_b_i,
  input  logic [WIDTH-1:0] req1_op_b_i,
  input  logic [3:0]       req0_ctrl_i,
  input  logic [3:0]       req1_ctrl_i,
  output logic             rsp0_valid_o,
  output logic             rsp1_valid_o,
  input  logic             rsp0_ready_i,
  input  logic             rsp1_ready_i,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic [WIDTH-1:0] alu_operand_a_o,
  output logic [WIDTH-1:0] alu_operand_b_o,
  output logic [3:0]       alu_control_o,
  input  logic [WIDTH-1:0] alu_data_i,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_prio;
  logic             r_gnt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [3:0]       r_ctrl;
  logic [WIDTH-1:0] r_result;

  logic w_rsp_hs;
  logic w_win;
  logic w_gnt0;
  logic w_gnt1;
  logic w_any_gnt;

  // Only the latched owner's ready counts; the other response port is ignored.
  assign w_rsp_hs  = (r_state == RESP) && (r_gnt ? rsp1_ready_i : rsp0_ready_i);
  // Reset gates the accept window so no ready escapes while rst_ni is low.
  assign w_win     = rst_ni && ((r_state == IDLE) || w_rsp_hs);
  assign w_gnt0    = w_win && req0_valid_i && (!req1_valid_i || (r_prio == 1'b0));
  assign w_gnt1    = w_win && req1_valid_i && (!req0_valid_i || (r_prio == 1'b1));
  assign w_any_gnt = w_gnt0 || w_gnt1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_any_gnt) w_state_nxt = EXEC;
      EXEC: w_state_nxt = RESP;
      RESP: if (w_rsp_hs) w_state_nxt = w_any_gnt ? EXEC : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prio   <= 1'b0;
      r_gnt    <= 1'b0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_ctrl   <= '0;
      r_result <= '0;
    end else begin
      if (w_any_gnt) begin
        r_op_a <= w_gnt1 ? req1_op_a_i : req0_op_a_i;
        r_op_b <= w_gnt1 ? req1_op_b_i : req0_op_b_i;
        r_ctrl <= w_gnt1 ? req1_ctrl_i : req0_ctrl_i;
        r_gnt  <= w_gnt1;
        // Priority passes to the requester that lost (or did not compete).
        r_prio <= w_gnt0;
      end
      if (r_state == EXEC) begin
        r_result <= alu_data_i;
      end
    end
  end

  assign req0_ready_o    = w_gnt0;
  assign req1_ready_o    = w_gnt1;
  assign rsp0_valid_o    = (r_state == RESP) && !r_gnt;
  assign rsp1_valid_o    = (r_state == RESP) && r_gnt;
  assign rsp_data_o      = r_result;
  assign alu_operand_a_o = r_op_a;
  assign alu_operand_b_o = r_op_b;
  assign alu_control_o   = r_ctrl;
  assign busy_o          = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scenario bench for alu_arbiter with a behavioural ALU and a transaction-level reference model.
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b1;
  logic         req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic         req0_ready_o, req1_ready_o;
  logic [W-1:0] req0_op_a_i = '0, req1_op_a_i = '0, req0_op_b_i = '0, req1_op_b_i = '0;
  logic [3:0]   req0_ctrl_i = '0, req1_ctrl_i = '0;
  logic         rsp0_valid_o, rsp1_valid_o;
  logic         rsp0_ready_i = 1'b0, rsp1_ready_i = 1'b0;
  logic [W-1:0] rsp_data_o, alu_operand_a_o, alu_operand_b_o, alu_data_i;
  logic [3:0]   alu_control_o;
  logic         busy_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req0_valid_i(req0_valid_i), .req1_valid_i(req1_valid_i),
    .req0_ready_o(req0_ready_o), .req1_ready_o(req1_ready_o),
    .req0_op_a_i(req0_op_a_i), .req1_op_a_i(req1_op_a_i),
    .req0_op_b_i(req0_op_b_i), .req1_op_b_i(req1_op_b_i),
    .req0_ctrl_i(req0_ctrl_i), .req1_ctrl_i(req1_ctrl_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp1_valid_o(rsp1_valid_o),
    .rsp0_ready_i(rsp0_ready_i), .rsp1_ready_i(rsp1_ready_i),
    .rsp_data_o(rsp_data_o),
    .alu_operand_a_o(alu_operand_a_o), .alu_operand_b_o(alu_operand_b_o),
    .alu_control_o(alu_control_o), .alu_data_i(alu_data_i),
    .busy_o(busy_o)
  );

  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] c);
    case (c)
      4'd0: alu_ref = a + b;
      4'd1: alu_ref = a - b;
      4'd2: alu_ref = a & b;
      4'd3: alu_ref = a | b;
      4'd4: alu_ref = a ^ b;
      4'd5: alu_ref = a << b[4:0];
      4'd6: alu_ref = a >> b[4:0];
      4'd7: alu_ref = $signed(a) >>> b[4:0];
      4'd8: alu_ref = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd9: alu_ref = {{(W-1){1'b0}}, (a < b)};
      default: alu_ref = b;
    endcase
  endfunction

  // The shared combinational ALU that sits outside the arbiter.
  assign alu_data_i = alu_ref(alu_operand_a_o, alu_operand_b_o, alu_control_o);

  task automatic do_reset();
    rst_ni = 1'b0;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    if ({req0_ready_o, req1_ready_o} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", {req0_ready_o, req1_ready_o}); end
    total++;
    if ({rsp0_valid_o, rsp1_valid_o} !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=00", {rsp0_valid_o, rsp1_valid_o}); end
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    total++;
    if ({alu_operand_a_o, alu_operand_b_o, alu_control_o, rsp_data_o} !== '0) begin
      bad++; $display("FAIL reset_regs got a=%h b=%h c=%h d=%h exp all zero", alu_operand_a_o, alu_operand_b_o, alu_control_o, rsp_data_o);
    end
    total++;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    rst_ni = 1'b1;
  endtask

  task automatic test_single_add();
    req0_op_a_i = 5; req0_op_b_i = 7; req0_ctrl_i = 4'b0000;
    req0_valid_i = 1'b1; rsp0_ready_i = 1'b1;
    #1;
    if ({req0_ready_o, req1_ready_o} !== 2'b10) begin bad++; $display("FAIL add_accept got=%b exp=10", {req0_ready_o, req1_ready_o}); end
    total++;
    @(posedge clk); #1; req0_valid_i = 1'b0; #1;
    if ({busy_o, rsp0_valid_o, req0_ready_o} !== 3'b100) begin bad++; $display("FAIL add_exec got=%b exp=100", {busy_o, rsp0_valid_o, req0_ready_o}); end
    total++;
    @(posedge clk); #1;
    if ({rsp0_valid_o, rsp1_valid_o} !== 2'b10) begin bad++; $display("FAIL add_rsp_valid got=%b exp=10", {rsp0_valid_o, rsp1_valid_o}); end
    total++;
    if (rsp_data_o !== 32'd12) begin bad++; $display("FAIL add_data got=%h exp=%h", rsp_data_o, 32'd12); end
    total++;
    @(posedge clk); #1;
    if ({busy_o, rsp0_valid_o} !== 2'b00) begin bad++; $display("FAIL add_done got=%b exp=00", {busy_o, rsp0_valid_o}); end
    total++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    req0_op_a_i = 10;    req0_op_b_i = 3;     req0_ctrl_i = 4'd1;
    req1_op_a_i = 'hF0;  req1_op_b_i = 'h0F;  req1_ctrl_i = 4'd4;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
    #1;
    if ({req0_ready_o, req1_ready_o} !== 2'b10) begin bad++; $display("FAIL sim_first_grant got=%b exp=10", {req0_ready_o, req1_ready_o}); end
    total++;
    @(posedge clk); #1; req0_valid_i = 1'b0; #1;
    if (req1_ready_o !== 1'b0) begin bad++; $display("FAIL sim_exec_ready got=%b exp=0", req1_ready_o); end
    total++;
    @(posedge clk); #1;
    if ({rsp0_valid_o, rsp_data_o} !== {1'b1, 32'd7}) begin bad++; $display("FAIL sim_rsp0 got=%b/%h exp=1/%h", rsp0_valid_o, rsp_data_o, 32'd7); end
    total++;
    if (req1_ready_o !== 1'b1) begin bad++; $display("FAIL sim_overlap_accept got=%b exp=1", req1_ready_o); end
    total++;
    @(posedge clk); #1; req1_valid_i = 1'b0; #1;
    if ({busy_o, rsp0_valid_o, rsp1_valid_o} !== 3'b100) begin bad++; $display("FAIL sim_exec2 got=%b exp=100", {busy_o, rsp0_valid_o, rsp1_valid_o}); end
    total++;
    @(posedge clk); #1;
    if ({rsp1_valid_o, rsp_data_o} !== {1'b1, 32'hFF}) begin bad++; $display("FAIL sim_rsp1 got=%b/%h exp=1/%h", rsp1_valid_o, rsp_data_o, 32'hFF); end
    total++;
    @(posedge clk); #1;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL sim_idle got=%b exp=0", busy_o); end
    total++;
  endtask

  task automatic test_contention();
    int own_q[$];
    logic [W-1:0] val_q[$];
    int gcount = 0;
    int vcount = 0;
    int last = -1;
    int g;
    do_reset();
    rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
    req0_op_a_i = $urandom; req0_op_b_i = $urandom; req0_ctrl_i = 4'($urandom_range(0, 15));
    req1_op_a_i = $urandom; req1_op_b_i = $urandom; req1_ctrl_i = 4'($urandom_range(0, 15));
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    for (int cyc = 0; cyc < 60 && vcount < 8; cyc++) begin
      #1;
      g = -1;
      if (req0_ready_o && req1_ready_o) begin bad++; $display("FAIL cont_double_grant cycle=%0d got=11 exp=one-hot", cyc); end
      total++;
      if (rsp0_valid_o || rsp1_valid_o) begin
        if (own_q.size() == 0) begin
          bad++; $display("FAIL cont_unexpected_rsp cycle=%0d got=%b exp=none", cyc, {rsp0_valid_o, rsp1_valid_o});
        end else begin
          if ({rsp1_valid_o, rsp0_valid_o, rsp_data_o} !== {own_q[0] == 1, own_q[0] == 0, val_q[0]}) begin
            bad++; $display("FAIL cont_rsp got=%b%b/%h exp=owner %0d data %h", rsp1_valid_o, rsp0_valid_o, rsp_data_o, own_q[0], val_q[0]);
          end
          void'(own_q.pop_front()); void'(val_q.pop_front());
        end
        total++;
        if (last >= 0) begin
          if (cyc - last != 2) begin bad++; $display("FAIL cont_rsp_spacing got=%0d exp=2", cyc - last); end
          total++;
        end
        last = cyc;
        vcount++;
      end
      if (req0_ready_o || req1_ready_o) begin
        g = req1_ready_o ? 1 : 0;
        if (g != gcount % 2) begin bad++; $display("FAIL cont_grant_order n=%0d got=%0d exp=%0d", gcount, g, gcount % 2); end
        total++;
        own_q.push_back(g);
        val_q.push_back(g == 1 ? alu_ref(req1_op_a_i, req1_op_b_i, req1_ctrl_i)
                               : alu_ref(req0_op_a_i, req0_op_b_i, req0_ctrl_i));
        gcount++;
      end
      @(posedge clk); #1;
      if (g == 0) begin req0_op_a_i = $urandom; req0_op_b_i = $urandom; req0_ctrl_i = 4'($urandom_range(0, 15)); end
      if (g == 1) begin req1_op_a_i = $urandom; req1_op_b_i = $urandom; req1_ctrl_i = 4'($urandom_range(0, 15)); end
    end
    if (vcount != 8) begin bad++; $display("FAIL cont_budget got=%0d exp=8 responses", vcount); end
    total++;
    do_reset();
  endtask

  task automatic test_backpressure();
    do_reset();
    req1_op_a_i = $urandom; req1_op_b_i = 32'h1; req1_ctrl_i = 4'b1111;
    req1_valid_i = 1'b1; rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b0;
    #1;
    if (req1_ready_o !== 1'b1) begin bad++; $display("FAIL bp_accept got=%b exp=1", req1_ready_o); end
    total++;
    @(posedge clk); #1; req1_valid_i = 1'b0;
    @(posedge clk); #1;
    req0_op_a_i = 2; req0_op_b_i = 2; req0_ctrl_i = 4'd0;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1; req1_op_b_i = $urandom;
    for (int i = 0; i < 5; i++) begin
      #1;
      if ({rsp1_valid_o, rsp0_valid_o, rsp_data_o} !== {2'b10, 32'h1}) begin
        bad++; $display("FAIL bp_hold cycle=%0d got=%b%b/%h exp=10/%h", i, rsp1_valid_o, rsp0_valid_o, rsp_data_o, 32'h1);
      end
      total++;
      if ({req0_ready_o, req1_ready_o} !== 2'b00) begin bad++; $display("FAIL bp_no_accept cycle=%0d got=%b exp=00", i, {req0_ready_o, req1_ready_o}); end
      total++;
      @(posedge clk); #1;
    end
    rsp1_ready_i = 1'b1; #1;
    if ({rsp1_valid_o, req0_ready_o, req1_ready_o} !== 3'b110) begin bad++; $display("FAIL bp_release got=%b exp=110", {rsp1_valid_o, req0_ready_o, req1_ready_o}); end
    total++;
    @(posedge clk); #1; req0_valid_i = 1'b0; req1_valid_i = 1'b0; rsp1_ready_i = 1'b0; #1;
    if ({rsp1_valid_o, busy_o} !== 2'b01) begin bad++; $display("FAIL bp_after got=%b exp=01", {rsp1_valid_o, busy_o}); end
    total++;
    @(posedge clk); #1;
    if ({rsp0_valid_o, rsp_data_o} !== {1'b1, 32'd4}) begin bad++; $display("FAIL bp_next got=%b/%h exp=1/%h", rsp0_valid_o, rsp_data_o, 32'd4); end
    total++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0_op_a_i = 1; req0_op_b_i = 31; req0_ctrl_i = 4'b0111;
    req0_valid_i = 1'b1; rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
    @(posedge clk); #1; req0_valid_i = 1'b0; req1_valid_i = 1'b1;
    #1 rst_ni = 1'b0; #1;
    if ({busy_o, rsp0_valid_o, rsp1_valid_o, req0_ready_o, req1_ready_o} !== 5'b0) begin
      bad++; $display("FAIL mid_reset_ctl got=%b exp=00000", {busy_o, rsp0_valid_o, rsp1_valid_o, req0_ready_o, req1_ready_o});
    end
    total++;
    if ({alu_operand_a_o, alu_operand_b_o, alu_control_o, rsp_data_o} !== '0) begin
      bad++; $display("FAIL mid_reset_regs got a=%h b=%h c=%h exp zero", alu_operand_a_o, alu_operand_b_o, alu_control_o);
    end
    total++;
    repeat (2) @(posedge clk);
    #1 req1_valid_i = 1'b0; rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if ({busy_o, rsp0_valid_o, rsp1_valid_o} !== 3'b000) begin bad++; $display("FAIL mid_no_rsp cycle=%0d got=%b exp=000", i, {busy_o, rsp0_valid_o, rsp1_valid_o}); end
      total++;
      @(posedge clk); #1;
    end
    req1_op_a_i = 2; req1_op_b_i = 3; req1_ctrl_i = 4'd0; req1_valid_i = 1'b1;
    @(posedge clk); #1; req1_valid_i = 1'b0;
    @(posedge clk); #1;
    if ({rsp1_valid_o, rsp_data_o} !== {1'b1, 32'd5}) begin bad++; $display("FAIL mid_next got=%b/%h exp=1/%h", rsp1_valid_o, rsp_data_o, 32'd5); end
    total++;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    logic [W-1:0] pat;
    pat = 32'hABCD0000;
    rsp0_ready_i = 1'b1;
    for (int code = 10; code < 16; code++) begin
      req0_op_a_i = $urandom; req0_op_b_i = pat; req0_ctrl_i = 4'(code);
      req0_valid_i = 1'b1;
      @(posedge clk); #1; req0_valid_i = 1'b0;
      @(posedge clk); #1;
      if ({rsp0_valid_o, rsp_data_o} !== {1'b1, pat}) begin bad++; $display("FAIL pass_code%0d got=%b/%h exp=1/%h", code, rsp0_valid_o, rsp_data_o, pat); end
      total++;
      @(posedge clk); #1;
      pat = pat ^ 32'h0000_1111;
    end
  endtask

  task automatic test_random();
    bit           v[2];
    logic [W-1:0] pa[2], pb[2];
    logic [3:0]   pc[2];
    bit           m_have = 0, m_vis = 0, m_prio = 0, hs;
    int           m_owner = 0, winner;
    logic [W-1:0] m_val = '0;
    bit           rr[2];
    do_reset();
    v[0] = 0; v[1] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (!v[n] && $urandom_range(0, 1) == 1) begin
          v[n] = 1; pa[n] = $urandom; pb[n] = $urandom; pc[n] = 4'($urandom_range(0, 15));
        end
        rr[n] = ($urandom_range(0, 2) != 0);
      end
      req0_valid_i = v[0]; req0_op_a_i = pa[0]; req0_op_b_i = pb[0]; req0_ctrl_i = pc[0];
      req1_valid_i = v[1]; req1_op_a_i = pa[1]; req1_op_b_i = pb[1]; req1_ctrl_i = pc[1];
      rsp0_ready_i = rr[0]; rsp1_ready_i = rr[1];
      #1;
      hs = m_have && m_vis && rr[m_owner];
      winner = -1;
      if (!m_have || hs) begin
        if (v[0] && v[1]) winner = int'(m_prio);
        else if (v[0])    winner = 0;
        else if (v[1])    winner = 1;
      end
      if ({req0_ready_o, req1_ready_o} !== {winner == 0, winner == 1}) begin
        bad++; $display("FAIL rnd_ready cycle=%0d got=%b%b exp winner=%0d", cyc, req0_ready_o, req1_ready_o, winner);
      end
      total++;
      if ({rsp0_valid_o, rsp1_valid_o, busy_o} !== {m_have && m_vis && m_owner == 0, m_have && m_vis && m_owner == 1, m_have}) begin
        bad++; $display("FAIL rnd_status cycle=%0d got=%b%b%b exp have=%0d vis=%0d owner=%0d", cyc, rsp0_valid_o, rsp1_valid_o, busy_o, m_have, m_vis, m_owner);
      end
      total++;
      if (m_have && m_vis) begin
        if (rsp_data_o !== m_val) begin bad++; $display("FAIL rnd_data cycle=%0d got=%h exp=%h", cyc, rsp_data_o, m_val); end
        total++;
      end
      @(posedge clk); #1;
      if (winner >= 0) begin
        m_have = 1; m_vis = 0; m_owner = winner;
        m_val = alu_ref(pa[winner], pb[winner], pc[winner]);
        m_prio = (winner == 0);
        v[winner] = 0;
      end else if (hs) begin
        m_have = 0;
      end else if (m_have) begin
        m_vis = 1;
      end
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_simultaneous();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_passthrough();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
